rs_allocator: RTL and testbench
===============================

# rs_allocator

Parametrised reservation-station entry allocator for the dispatch stage. It keeps the busy state for every station class, such as ALU and branch. On each dispatch it grants one free entry of the requested class, and it releases entries when they issue or when the pipeline flushes. Allocation is round-robin within each class, which evens out entry use and avoids starving high-index entries.

## Interface
Parameters:
- NUM_CLASSES, 2: number of station classes. Class 0 is ALU, class 1 is BRANCH.
- ENTRIES, 8: entries per class.
- CLASS_W, $clog2(NUM_CLASSES) (minimum 1): class field width.
- IDX_W, $clog2(ENTRIES): entry index width.
- CNT_W, $clog2(ENTRIES+1): free-count width.

Ports:
- clk  in  1  system clock. One clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dispatchValid  in  1  dispatch requests an entry.
- dispatchClass  in  CLASS_W  requested class.
- dispatchReady  out  1  requested class has a free entry.
- grantValid  out  1  allocation occurs this cycle (dispatchValid & dispatchReady).
- grantIndex  out  IDX_W  granted entry index.
- grantOneHot  out  ENTRIES  one-hot write request for the granted entry, zero when no grant.
- issueFree  in  NUM_CLASSES*ENTRIES  entries released this cycle (multi-hot). Bit c*ENTRIES+i means class c, entry i.
- flush  in  1  clear all busy bits.
- busyVector  out  NUM_CLASSES*ENTRIES  registered busy state.
- freeCount  out  NUM_CLASSES*CNT_W  registered free entries per class.
- classFull  out  NUM_CLASSES  registered per class, freeCount==0.

## Operation
- State per class: busy[ENTRIES] and round-robin pointer ptr[IDX_W].
- Pick: search for the first non-busy entry starting at ptr[cls] and moving upward, wrapping modulo ENTRIES. The search uses only the registered busy state.
- dispatchReady = (dispatchClass < NUM_CLASSES) & ~classFull[dispatchClass]. dispatchReady does not depend on dispatchValid.
- An out-of-range class gives dispatchReady=0 and no grant.
- On grant, at the next edge:
  - busy[cls][idx] <= 1.
  - ptr[cls] <= idx+1, wrapping to 0 at ENTRIES.
- Free: for each set issueFree bit, busy <= 0 at the next edge. A free bit on a non-busy entry is ignored.
- Next-state precedence: reset > flush > (allocate set | free clear).
  - Allocation and free never target the same entry in one cycle, because allocation only picks non-busy entries.
- Flush: all busy <= 0 and all ptr <= 0. Any grant in the flush cycle is discarded.
- freeCount[c] = ENTRIES − popcount(busy[c]). It is recomputed from next-state busy and registered, so it always matches busyVector.

## Timing
- Grant is combinational from the registered state: request and grant happen in the same cycle, and busyVector reflects the grant one cycle later.
- An entry freed in cycle N can be granted in cycle N+1 at the earliest. There is no free-to-allocate bypass.
- A full class with a free arriving in cycle N: dispatchReady=0 in N, 1 in N+1.
- Reset values:
  - Registered: busyVector=0, all ptr=0, freeCount=ENTRIES per class, classFull=0.
  - Combinational outputs in the reset cycle: grantValid=0, grantOneHot=0, grantIndex=0. dispatchReady is forced to 0.
- Reset or flush asserted mid-stream overrides any same-cycle grant or free. Operation resumes the following cycle with everything free.
- Throughput: one allocation per cycle, with any number of frees.

## Structure
- Package rs_pkg:
  - Class encoding enum: RS_ALU=0, RS_BRANCH=1.
  - Default NUM_CLASSES and ENTRIES constants.
- Sub-module rr_free_picker (parameter ENTRIES):
  - Inputs: busy vector and start pointer.
  - Outputs: found, index, one-hot.
  - Implementation: rotate, priority-find, unrotate. One instance per class; the output is muxed by dispatchClass.
- Per-class state lives in generate loops. Flat vectors are sliced with c*ENTRIES.

## Test plan
1. After reset, dispatch class 0 for 8 consecutive cycles → grantIndex 0,1,…,7. On the 9th cycle dispatchReady=0 and classFull[0]=1.
2. ALU full, issueFree bit 3 in cycle N → dispatchReady=1 in N+1, grantIndex=3, freeCount[0] goes 1→0.
3. Round-robin: grant 0 and 1, free entry 0, dispatch again → grantIndex=2, not 0. After entries 2–7 are granted, the pointer wraps and the next grant is 0.
4. Class 1 and class 0 interleaved → independent pointers. A class 1 grant leaves busyVector[7:0] unchanged. dispatchClass=2 with NUM_CLASSES=2 → dispatchReady=0, grantOneHot=0.
5. Dispatch together with flush in the same cycle → busyVector=0 and freeCount=ENTRIES the next cycle. The next dispatch grants index 0.
6. Reset mid-stream with 5 busy ALU entries → all outputs at reset values next cycle. A free of a non-busy entry is ignored, and freeCount stays at 8.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station allocator.
package rs_pkg;

   // Station class encoding
   typedef enum logic [0:0] {
      RS_ALU    = 1'b0,
      RS_BRANCH = 1'b1
   } rs_class_e;

   localparam int RS_NUM_CLASSES = 2;
   localparam int RS_ENTRIES     = 8;

endpackage

// File: rtl/rs_allocator_rr_free_picker.sv
// Round-robin free-entry finder: first non-busy entry at or above ptr_i, wrapping.
module rr_free_picker
   import rs_pkg::*;
#(
   parameter int ENTRIES = RS_ENTRIES,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic [ENTRIES-1:0] busy_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   index_o,
   output logic [ENTRIES-1:0] onehot_o
);

   logic [ENTRIES-1:0] free_rot;
   logic [IDX_W-1:0]   off;
   logic [IDX_W:0]     pos;

   // Rotate the free mask so ptr_i lands at bit 0, priority-find, then rotate back
   always_comb begin
      free_rot = '0;
      for (int k = 0; k < ENTRIES; k++) begin
         logic [IDX_W:0] s;
         s = {1'b0, ptr_i} + (IDX_W+1)'(k);
         if (s >= (IDX_W+1)'(ENTRIES)) s = s - (IDX_W+1)'(ENTRIES);
         free_rot[k] = ~busy_i[s[IDX_W-1:0]];
      end
      found_o = 1'b0;
      off     = '0;
      for (int k = ENTRIES-1; k >= 0; k--) begin
         if (free_rot[k]) begin
            found_o = 1'b1;
            off     = IDX_W'(k);
         end
      end
      pos = {1'b0, off} + {1'b0, ptr_i};
      if (pos >= (IDX_W+1)'(ENTRIES)) pos = pos - (IDX_W+1)'(ENTRIES);
      index_o  = pos[IDX_W-1:0];
      onehot_o = '0;
      if (found_o) onehot_o[index_o] = 1'b1;
   end

endmodule

// File: rtl/rs_allocator.sv
// Reservation-station entry allocator: per-class busy bits, round-robin grant,
// multi-hot release on issue, global clear on flush.
module rs_allocator
   import rs_pkg::*;
#(
   parameter int NUM_CLASSES = RS_NUM_CLASSES,
   parameter int ENTRIES     = RS_ENTRIES,
   parameter int CLASS_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
   parameter int IDX_W       = $clog2(ENTRIES),
   parameter int CNT_W       = $clog2(ENTRIES+1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           dispatchValid,
   input  logic [CLASS_W-1:0]             dispatchClass,
   output logic                           dispatchReady,
   output logic                           grantValid,
   output logic [IDX_W-1:0]               grantIndex,
   output logic [ENTRIES-1:0]             grantOneHot,
   input  logic [NUM_CLASSES*ENTRIES-1:0] issueFree,
   input  logic                           flush,
   output logic [NUM_CLASSES*ENTRIES-1:0] busyVector,
   output logic [NUM_CLASSES*CNT_W-1:0]   freeCount,
   output logic [NUM_CLASSES-1:0]         classFull
);

   logic [NUM_CLASSES*ENTRIES-1:0]          busy_q, busy_d;
   logic [NUM_CLASSES-1:0][IDX_W-1:0]       ptr_q, ptr_d;
   logic [NUM_CLASSES-1:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_CLASSES-1:0]                  full_q, full_d;

   logic [NUM_CLASSES-1:0]                  pick_found;
   logic [NUM_CLASSES-1:0][IDX_W-1:0]       pick_idx;
   logic [NUM_CLASSES-1:0][ENTRIES-1:0]     pick_oh;

   logic                                    sel_hit, sel_full, sel_found;
   logic [IDX_W-1:0]                        sel_idx;
   logic [ENTRIES-1:0]                      sel_oh;

   // Mux the requested class's picker result; out-of-range classes never hit
   always_comb begin
      sel_hit   = 1'b0;
      sel_full  = 1'b0;
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_oh    = '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         if (dispatchClass == CLASS_W'(c)) begin
            sel_hit   = 1'b1;
            sel_full  = full_q[c];
            sel_found = pick_found[c];
            sel_idx   = pick_idx[c];
            sel_oh    = pick_oh[c];
         end
      end
   end

   assign dispatchReady = sel_hit & ~sel_full & sel_found & ~reset;
   assign grantValid    = dispatchValid & dispatchReady;
   assign grantIndex    = grantValid ? sel_idx : '0;
   assign grantOneHot   = grantValid ? sel_oh  : '0;

   for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
      logic               grant_c;
      logic [ENTRIES-1:0] b_d;
      logic [IDX_W-1:0]   p_d;
      logic [CNT_W-1:0]   n_d;

      rr_free_picker #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_pick (
         .busy_i   (busy_q[c*ENTRIES +: ENTRIES]),
         .ptr_i    (ptr_q[c]),
         .found_o  (pick_found[c]),
         .index_o  (pick_idx[c]),
         .onehot_o (pick_oh[c])
      );

      assign grant_c = grantValid & (dispatchClass == CLASS_W'(c));

      // Next busy/pointer for this class; flush wins, then set-on-grant | clear-on-free
      always_comb begin
         b_d = (busy_q[c*ENTRIES +: ENTRIES] & ~issueFree[c*ENTRIES +: ENTRIES])
             | (grant_c ? pick_oh[c] : '0);
         p_d = ptr_q[c];
         if (grant_c) begin
            if (pick_idx[c] == IDX_W'(ENTRIES-1)) p_d = '0;
            else                                  p_d = pick_idx[c] + 1'b1;
         end
         if (flush) begin
            b_d = '0;
            p_d = '0;
         end
         n_d = CNT_W'(ENTRIES);
         for (int i = 0; i < ENTRIES; i++) n_d = n_d - CNT_W'(b_d[i]);
      end

      assign busy_d[c*ENTRIES +: ENTRIES] = b_d;
      assign ptr_d[c]  = p_d;
      assign cnt_d[c]  = n_d;
      assign full_d[c] = (n_d == '0);
   end

   // State registers; free count and full flag derive from next-state busy
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         ptr_q  <= '0;
         for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= CNT_W'(ENTRIES);
         full_q <= '0;
      end else begin
         busy_q <= busy_d;
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   end

   assign busyVector = busy_q;
   assign freeCount  = cnt_q;
   assign classFull  = full_q;

endmodule

// File: tb/tb_rs_allocator.sv
// Scoreboard bench for rs_allocator: expected grant indices are queued with the
// stimulus and popped by a monitor whenever grantValid is seen.
module tb_rs_allocator;

   localparam int NC = 2;
   localparam int E  = 8;
   localparam int CW = 2;   // wide enough to drive out-of-range classes 2 and 3
   localparam int IW = 3;
   localparam int NW = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           dispatchValid;
   logic [CW-1:0]  dispatchClass;
   logic           dispatchReady;
   logic           grantValid;
   logic [IW-1:0]  grantIndex;
   logic [E-1:0]   grantOneHot;
   logic [NC*E-1:0] issueFree;
   logic           flush;
   logic [NC*E-1:0] busyVector;
   logic [NC*NW-1:0] freeCount;
   logic [NC-1:0]  classFull;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   rs_allocator #(.NUM_CLASSES(NC), .ENTRIES(E), .CLASS_W(CW)) dut (
      .clk(clk), .reset(reset),
      .dispatchValid(dispatchValid), .dispatchClass(dispatchClass),
      .dispatchReady(dispatchReady), .grantValid(grantValid),
      .grantIndex(grantIndex), .grantOneHot(grantOneHot),
      .issueFree(issueFree), .flush(flush),
      .busyVector(busyVector), .freeCount(freeCount), .classFull(classFull)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus just after the rising edge, then let it settle
   task automatic step(input logic dv, input int cls, input logic [NC*E-1:0] fr,
                       input logic fl, input logic rst);
      @(posedge clk);
      #1;
      dispatchValid = dv;
      dispatchClass = CW'(cls);
      issueFree     = fr;
      flush         = fl;
      reset         = rst;
      #1;
   endtask

   task automatic disp(input int cls, input int exp_idx);
      step(1'b1, cls, '0, 1'b0, 1'b0);
      exp_q.push_back(exp_idx);
      chk("ready_on_dispatch", {31'd0, dispatchReady}, 32'd1);
   endtask

   // Monitor: compare each observed grant against the scoreboard
   always @(negedge clk) begin
      if (grantValid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got index %0d, expected no grant", grantIndex);
         end else begin
            int e;
            logic [E-1:0] oh;
            e  = exp_q.pop_front();
            oh = '0;
            oh[e] = 1'b1;
            chk("grant_index", {29'd0, grantIndex}, 32'(e));
            chk("grant_onehot", {24'd0, grantOneHot}, {24'd0, oh});
         end
      end else begin
         chk("onehot_idle", {24'd0, grantOneHot}, 32'd0);
      end
   end

   initial begin
      reset = 1'b1; dispatchValid = 1'b0; dispatchClass = '0; issueFree = '0; flush = 1'b0;

      // Reset: a request during reset must not be granted
      step(1'b1, 0, '0, 1'b0, 1'b1);
      chk("reset_ready", {31'd0, dispatchReady}, 32'd0);
      chk("reset_grant", {31'd0, grantValid}, 32'd0);
      chk("reset_gidx", {29'd0, grantIndex}, 32'd0);
      step(1'b0, 0, '0, 1'b0, 1'b1);
      chk("reset_busy", {16'd0, busyVector}, 32'h0);
      chk("reset_free", {24'd0, freeCount}, 32'h88);
      chk("reset_full", {30'd0, classFull}, 32'h0);

      // Fill ALU in order 0..7, then it is full
      for (int i = 0; i < E; i++) disp(0, i);
      step(1'b1, 0, '0, 1'b0, 1'b0);
      chk("full_ready", {31'd0, dispatchReady}, 32'd0);
      chk("full_grant", {31'd0, grantValid}, 32'd0);
      chk("full_flag", {30'd0, classFull}, 32'h1);
      chk("full_count", {24'd0, freeCount}, 32'h80);
      chk("full_busy", {16'd0, busyVector}, 32'h00FF);

      // Free entry 3 while full: ready only the next cycle
      step(1'b0, 0, 16'h0008, 1'b0, 1'b0);
      chk("free_same_cycle_ready", {31'd0, dispatchReady}, 32'd0);
      disp(0, 3);
      chk("free_count_1", {24'd0, freeCount}, 32'h81);
      step(1'b0, 0, '0, 1'b0, 1'b0);
      chk("free_count_0", {24'd0, freeCount}, 32'h80);
      chk("refill_busy", {16'd0, busyVector}, 32'h00FF);

      // Round-robin: freed low entry is skipped until the pointer wraps
      step(1'b0, 0, '0, 1'b1, 1'b0);
      disp(0, 0);
      chk("flush_busy", {16'd0, busyVector}, 32'h0);
      disp(0, 1);
      step(1'b0, 0, 16'h0001, 1'b0, 1'b0);
      for (int i = 2; i < 7; i++) disp(0, i);
      step(1'b1, 0, 16'h0020, 1'b0, 1'b0);   // grant 7 and free 5 together
      exp_q.push_back(7);
      disp(0, 0);
      chk("wrap_busy", {16'd0, busyVector}, 32'h00DE);
      disp(0, 5);

      // Interleaved classes keep independent pointers and busy bits
      step(1'b0, 0, '0, 1'b1, 1'b0);
      disp(0, 0);
      chk("il_busy0", {16'd0, busyVector}, 32'h0000);
      disp(1, 0);
      chk("il_busy1", {16'd0, busyVector}, 32'h0001);
      disp(0, 1);
      chk("il_busy2", {16'd0, busyVector}, 32'h0101);
      disp(1, 1);
      chk("il_busy3", {16'd0, busyVector}, 32'h0103);
      disp(1, 2);
      chk("il_busy4", {16'd0, busyVector}, 32'h0303);
      step(1'b1, 2, '0, 1'b0, 1'b0);
      chk("il_busy5", {16'd0, busyVector}, 32'h0703);
      chk("cls2_ready", {31'd0, dispatchReady}, 32'd0);
      chk("cls2_grant", {31'd0, grantValid}, 32'd0);
      step(1'b1, 3, '0, 1'b0, 1'b0);
      chk("cls3_ready", {31'd0, dispatchReady}, 32'd0);
      chk("cls2_busy", {16'd0, busyVector}, 32'h0703);

      // Dispatch in the flush cycle: grant shown but discarded
      step(1'b1, 0, '0, 1'b1, 1'b0);
      exp_q.push_back(2);
      chk("pre_flush_count", {24'd0, freeCount}, 32'h56);
      disp(0, 0);
      chk("post_flush_busy", {16'd0, busyVector}, 32'h0);
      chk("post_flush_count", {24'd0, freeCount}, 32'h88);

      // Reset mid-stream with five ALU entries busy
      for (int i = 1; i < 5; i++) disp(0, i);
      step(1'b0, 0, '0, 1'b0, 1'b0);
      chk("five_busy", {16'd0, busyVector}, 32'h001F);
      chk("five_count", {24'd0, freeCount}, 32'h83);
      step(1'b1, 0, 16'h0001, 1'b0, 1'b1);
      chk("mid_reset_ready", {31'd0, dispatchReady}, 32'd0);
      chk("mid_reset_grant", {31'd0, grantValid}, 32'd0);
      step(1'b0, 0, 16'h0004, 1'b0, 1'b0);
      chk("mid_reset_busy", {16'd0, busyVector}, 32'h0);
      chk("mid_reset_count", {24'd0, freeCount}, 32'h88);
      chk("mid_reset_full", {30'd0, classFull}, 32'h0);
      disp(0, 0);
      chk("ignored_free_count", {24'd0, freeCount}, 32'h88);
      chk("ignored_free_busy", {16'd0, busyVector}, 32'h0);
      step(1'b0, 0, '0, 1'b0, 1'b0);
      chk("after_reset_busy", {16'd0, busyVector}, 32'h0001);

      step(1'b0, 0, '0, 1'b0, 1'b0);
      @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
